// File: rtl/fft_mag_peak.sv
// Streaming |X|^2 with per-frame peak search over N = 2^LAYER bins.
// Optional frame-energy output is enabled by defining FFT_MAG_PEAK_ENERGY_EN.
//
// state | meaning
// IDLE  | waiting for a sample flagged in_first
// RUN   | inside a frame, tracking running peak and bin index
module fft_mag_peak #(
    parameter int DW    = 32,
    parameter int LAYER = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [DW-1:0]   in_real,
    input  logic signed [DW-1:0]   in_img,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   mag_valid,
    output logic [2*DW-1:0]        mag_sq,
    output logic                   peak_valid,
    output logic [2*DW-1:0]        peak_mag,
    output logic [LAYER-1:0]       peak_idx,
    output logic                   frame_err
`ifdef FFT_MAG_PEAK_ENERGY_EN
    ,
    output logic [2*DW+LAYER-1:0]  frame_energy
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [LAYER-1:0] LAST_IDX = '1;

    state_t state_q, state_d;

    logic signed [2*DW-1:0] re_ext, im_ext;
    logic signed [2*DW-1:0] rr_q, ii_q;
    logic                   v1_q, first1_q, last1_q;
    logic                   v2_q, first2_q, last2_q;
    logic [2*DW-1:0]        mag_q;

    logic [LAYER-1:0]       idx_q, idx_d, run_idx_q, run_idx_d, peak_idx_q, peak_idx_d;
    logic [2*DW-1:0]        run_peak_q, run_peak_d, peak_mag_q, peak_mag_d;
    logic                   peak_valid_q, frame_err_q;
    logic [LAYER-1:0]       new_idx;
    logic                   at_end, better;
    logic                   load_s, add_s, pub_s, err_s;

    // Sign-extend before squaring so the full-range product is exact.
    assign re_ext  = (2*DW)'(in_real);
    assign im_ext  = (2*DW)'(in_img);

    assign new_idx = idx_q + LAYER'(1);
    assign at_end  = (new_idx == LAST_IDX);
    assign better  = (mag_q > run_peak_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (v2_q) begin
            case (state_q)
                IDLE: if (first2_q && !last2_q && LAYER > 0) state_d = RUN;
                RUN: begin
                    if (first2_q)                state_d = last2_q ? IDLE : RUN;
                    else if (last2_q || at_end)  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_s = 1'b0;
        add_s  = 1'b0;
        pub_s  = 1'b0;
        err_s  = 1'b0;
        if (v2_q) begin
            case (state_q)
                IDLE: begin
                    if (first2_q) begin
                        load_s = 1'b1;
                        if (LAYER == 0) begin
                            pub_s = last2_q;
                            err_s = !last2_q;
                        end else begin
                            err_s = last2_q;
                        end
                    end
                end
                RUN: begin
                    if (first2_q) begin
                        err_s  = 1'b1;
                        load_s = !last2_q;
                    end else begin
                        add_s = 1'b1;
                        if (last2_q) begin
                            pub_s = at_end;
                            err_s = !at_end;
                        end else begin
                            err_s = at_end;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        idx_d      = idx_q;
        run_peak_d = run_peak_q;
        run_idx_d  = run_idx_q;
        if (load_s) begin
            idx_d      = '0;
            run_peak_d = mag_q;
            run_idx_d  = '0;
        end else if (add_s) begin
            idx_d      = new_idx;
            run_peak_d = better ? mag_q : run_peak_q;
            run_idx_d  = better ? new_idx : run_idx_q;
        end
        peak_mag_d = peak_mag_q;
        peak_idx_d = peak_idx_q;
        if (pub_s) begin
            peak_mag_d = run_peak_d;
            peak_idx_d = run_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= '0;
            ii_q         <= '0;
            v1_q         <= 1'b0;
            first1_q     <= 1'b0;
            last1_q      <= 1'b0;
            v2_q         <= 1'b0;
            first2_q     <= 1'b0;
            last2_q      <= 1'b0;
            mag_q        <= '0;
            idx_q        <= '0;
            run_peak_q   <= '0;
            run_idx_q    <= '0;
            peak_mag_q   <= '0;
            peak_idx_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rr_q         <= re_ext * re_ext;
            ii_q         <= im_ext * im_ext;
            v1_q         <= in_valid;
            first1_q     <= in_first;
            last1_q      <= in_last;
            v2_q         <= v1_q;
            first2_q     <= first1_q;
            last2_q      <= last1_q;
            mag_q        <= $unsigned(rr_q) + $unsigned(ii_q);
            idx_q        <= idx_d;
            run_peak_q   <= run_peak_d;
            run_idx_q    <= run_idx_d;
            peak_mag_q   <= peak_mag_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= pub_s;
            frame_err_q  <= err_s;
        end
    end

    assign mag_valid  = v2_q;
    assign mag_sq     = mag_q;
    assign peak_valid = peak_valid_q;
    assign peak_mag   = peak_mag_q;
    assign peak_idx   = peak_idx_q;
    assign frame_err  = frame_err_q;

`ifdef FFT_MAG_PEAK_ENERGY_EN
    localparam int EW = 2*DW + LAYER;

    logic [EW-1:0] acc_q, acc_d, energy_q, energy_d, mag_ext;

    assign mag_ext = EW'(mag_q);

    always_comb begin
        acc_d = acc_q;
        if (load_s)     acc_d = mag_ext;
        else if (add_s) acc_d = acc_q + mag_ext;
        energy_d = pub_s ? acc_d : energy_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            energy_q <= '0;
        end else begin
            acc_q    <= acc_d;
            energy_q <= energy_d;
        end
    end

    assign frame_energy = energy_q;
`endif

endmodule

// File: tb/tb_fft_mag_peak.sv
// Directed bench for fft_mag_peak (DW=16, LAYER=3) with queue-based scoreboards
// for the magnitude stream and the per-frame peak/error events.
module tb_fft_mag_peak;
    localparam int DW    = 16;
    localparam int LAYER = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_first, in_last;
    logic signed [DW-1:0] in_real, in_img;
    logic                 mag_valid, peak_valid, frame_err;
    logic [2*DW-1:0]      mag_sq, peak_mag;
    logic [LAYER-1:0]     peak_idx;
`ifdef FFT_MAG_PEAK_ENERGY_EN
    logic [2*DW+LAYER-1:0] frame_energy;
`endif

    fft_mag_peak #(.DW(DW), .LAYER(LAYER)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_img     (in_img),
        .in_first   (in_first),
        .in_last    (in_last),
        .mag_valid  (mag_valid),
        .mag_sq     (mag_sq),
        .peak_valid (peak_valid),
        .peak_mag   (peak_mag),
        .peak_idx   (peak_idx),
        .frame_err  (frame_err)
`ifdef FFT_MAG_PEAK_ENERGY_EN
        ,
        .frame_energy (frame_energy)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int due; logic [31:0] mag;} mexp_t;
    typedef struct {int due; bit pk; logic [31:0] mag; logic [2:0] idx; logic [34:0] en;} eexp_t;

    mexp_t mq[$];
    eexp_t eq[$];
    mexp_t mtmp;
    eexp_t etmp;

    int n_chk  = 0;
    int n_pass = 0;
    int s_cyc  = 0;

    logic [31:0] hold_mag = '0;
    logic [2:0]  hold_idx = '0;
    logic [34:0] hold_en  = '0;

    int fr_re[8];
    int fr_im[8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    endtask

    task automatic drive(input logic v, input int re, input int im,
                         input logic f, input logic l, input logic r = 1'b0);
        longint p;
        @(posedge clk);
        #1;
        rst      = r;
        in_valid = v;
        in_real  = 16'(re);
        in_img   = 16'(im);
        in_first = f;
        in_last  = l;
        s_cyc    = cyc;
        if (r) begin
            // Samples still in flight past this cycle are flushed by the reset.
            while (mq.size() > 0 && mq[$].due > cyc) void'(mq.pop_back());
            while (eq.size() > 0 && eq[$].due > cyc) void'(eq.pop_back());
            hold_mag = '0;
            hold_idx = '0;
            hold_en  = '0;
        end else if (v) begin
            p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
            mq.push_back('{due: cyc + 2, mag: p[31:0]});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic exp_peak(input logic [31:0] m, input logic [2:0] i, input logic [34:0] e);
        hold_mag = m;
        hold_idx = i;
        hold_en  = e;
        eq.push_back('{due: s_cyc + 3, pk: 1'b1, mag: m, idx: i, en: e});
    endtask

    task automatic exp_err();
        eq.push_back('{due: s_cyc + 3, pk: 1'b0, mag: hold_mag, idx: hold_idx, en: hold_en});
    endtask

    task automatic send_frame(input int n, input int last_at, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, fr_re[i], fr_im[i], i == 0, i == last_at);
            if (gap > 0 && i != n - 1) idle(gap);
        end
    endtask

    task automatic calc(output logic [31:0] bm, output logic [2:0] bi, output logic [34:0] en);
        longint m, best, sum;
        best = 0;
        sum  = 0;
        bi   = '0;
        for (int i = 0; i < 8; i++) begin
            m = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
            if (i == 0 || m > best) begin
                best = m;
                bi   = 3'(i);
            end
            sum += m;
        end
        bm = best[31:0];
        en = sum[34:0];
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mag_valid"}, mag_valid, 0);
        chk({tag, "_mag_sq"}, mag_sq, 0);
        chk({tag, "_peak_valid"}, peak_valid, 0);
        chk({tag, "_peak_mag"}, peak_mag, 0);
        chk({tag, "_peak_idx"}, peak_idx, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
`ifdef FFT_MAG_PEAK_ENERGY_EN
        chk({tag, "_frame_energy"}, frame_energy, 0);
`endif
    endtask

    always @(negedge clk) begin
        if (mag_valid === 1'b1 || (mq.size() > 0 && mq[0].due == cyc)) begin
            if (mq.size() == 0) begin
                chk("mag_unexpected", mag_valid, 0);
            end else begin
                mtmp = mq.pop_front();
                chk("mag_valid", mag_valid, 1);
                chk("mag_cycle", cyc, mtmp.due);
                chk("mag_sq", mag_sq, mtmp.mag);
            end
        end
        if (peak_valid === 1'b1 || frame_err === 1'b1 || (eq.size() > 0 && eq[0].due == cyc)) begin
            if (eq.size() == 0) begin
                chk("event_unexpected", {peak_valid, frame_err}, 0);
            end else begin
                etmp = eq.pop_front();
                chk("peak_valid", peak_valid, etmp.pk);
                chk("frame_err", frame_err, !etmp.pk);
                chk("event_cycle", cyc, etmp.due);
                chk("peak_mag", peak_mag, etmp.mag);
                chk("peak_idx", peak_idx, etmp.idx);
`ifdef FFT_MAG_PEAK_ENERGY_EN
                chk("frame_energy", frame_energy, etmp.en);
`endif
            end
        end
    end

    logic [31:0] bm;
    logic [2:0]  bi;
    logic [34:0] be;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_real  = '0;
        in_img   = '0;
        in_first = 1'b0;
        in_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        idle(2);

        // Full-scale negative sample outside a frame: magnitude only, no event.
        drive(1'b1, -32768, -32768, 1'b0, 1'b0);
        idle(4);

        // Ramp frame followed back-to-back by an all-equal frame.
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = i;
            fr_im[i] = 0;
        end
        send_frame(8, 7, 0);
        exp_peak(32'd49, 3'd7, 35'd140);
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 3;
            fr_im[i] = 4;
        end
        send_frame(8, 7, 0);
        exp_peak(32'd25, 3'd0, 35'd200);
        idle(3);

        // Random frame with bubbles between samples.
        rand_frame();
        send_frame(8, 7, 2);
        calc(bm, bi, be);
        exp_peak(bm, bi, be);
        idle(4);

        // Early in_last, then a correct frame straight after.
        for (int i = 0; i < 8; i++) begin
            fr_re[i] = 100 + i;
            fr_im[i] = -i;
        end
        send_frame(5, 4, 0);
        exp_err();
        rand_frame();
        send_frame(8, 7, 0);
        calc(bm, bi, be);
        exp_peak(bm, bi, be);
        idle(4);

        // in_first on sample 4 restarts the frame; earlier large samples are dropped.
        for (int i = 0; i < 4; i++) drive(1'b1, 1000, 1000, i == 0, 1'b0);
        fr_re = '{1, 2, 50, 3, 0, -7, 10, 49};
        fr_im = '{0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, fr_re[i], fr_im[i], i == 0, i == 7);
            if (i == 0) exp_err();
        end
        exp_peak(32'd2500, 3'd2, 35'd5064);
        idle(4);

        // Index reaches N-1 without in_last.
        rand_frame();
        send_frame(8, -1, 0);
        exp_err();
        idle(4);

        // in_first and in_last on one sample.
        drive(1'b1, 5, 5, 1'b1, 1'b1);
        exp_err();
        idle(4);

        // Reset on sample 6 of a frame abandons it.
        rand_frame();
        send_frame(6, -1, 0);
        drive(1'b1, 123, 456, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_zero("midrst");
        idle(2);

        rand_frame();
        send_frame(8, 7, 0);
        calc(bm, bi, be);
        exp_peak(bm, bi, be);
        idle(10);

        chk("mag_queue_drained", mq.size(), 0);
        chk("event_queue_drained", eq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
